// File: rtl/jtag_dbg_pkg.sv
// Shared types for the JTAG debug sequencer: opcodes, FSM states and the
// registered output bundle decoded from each state.
package jtag_dbg_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP        = 3'd0;
    localparam logic [OP_W-1:0] OP_HALT       = 3'd1;
    localparam logic [OP_W-1:0] OP_RESUME     = 3'd2;
    localparam logic [OP_W-1:0] OP_STEP       = 3'd3;
    localparam logic [OP_W-1:0] OP_SCAN       = 3'd4;
    localparam logic [OP_W-1:0] OP_CORE_RESET = 3'd5;

    typedef enum logic [OP_W-1:0] {
        OpNop       = OP_NOP,
        OpHalt      = OP_HALT,
        OpResume    = OP_RESUME,
        OpStep      = OP_STEP,
        OpScan      = OP_SCAN,
        OpCoreReset = OP_CORE_RESET
    } dbg_op_e;

    typedef enum logic [2:0] {
        StRstHold,
        StRun,
        StHalted,
        StStep,
        StCapture,
        StShift,
        StUpdate
    } dbg_state_e;

    typedef struct packed {
        logic core_en;
        logic core_reset;
        logic cmd_ready;
        logic halted;
        logic scan_capture;
        logic scan_en;
        logic scan_update;
    } dbg_out_t;

    // Every non-sticky output is a pure function of the state being entered.
    function automatic dbg_out_t state_outputs(input dbg_state_e s);
        dbg_out_t o;
        o              = '0;
        o.core_en      = (s == StRun) || (s == StStep);
        o.core_reset   = (s == StRstHold);
        o.cmd_ready    = (s == StRun) || (s == StHalted);
        o.halted       = (s == StHalted);
        o.scan_capture = (s == StCapture);
        o.scan_en      = (s == StShift);
        o.scan_update  = (s == StUpdate);
        return o;
    endfunction

endpackage

// File: rtl/jtag_debug_ctrl_if.sv
// Command handshake between the TCK-domain synchronizer and the sequencer.
interface jtag_debug_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import jtag_dbg_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [CNT_W-1:0]  cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );

endinterface

// File: rtl/dbg_down_counter.sv
// Loadable saturating down-counter shared by reset hold, STEP and SHIFT.
module dbg_down_counter #(
    parameter int unsigned      CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/jtag_debug_ctrl.sv
// System-clock sequencer driving core clock-enable, core reset and scan strobes
// from synchronized JTAG debug commands.
module jtag_debug_ctrl
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned CNT_W             = 16,
    parameter int unsigned RESET_CYCLES      = 4,
    parameter bit          AUTO_HALT_ON_DONE = 1'b1
) (
    input  logic                i_sysclk,
    input  logic                i_sys_reset,
    jtag_debug_ctrl_if.slave    cmd_if,
    input  logic                i_core_done,
    output logic                o_core_en,
    output logic                o_core_reset,
    output logic                o_scan_capture,
    output logic                o_scan_en,
    output logic                o_scan_update,
    output logic                o_halted,
    output logic                o_done_seen,
    output logic                o_cmd_err
);

    localparam logic [CNT_W-1:0] RstCnt = CNT_W'(RESET_CYCLES - 1);

    dbg_state_e       r_state;
    dbg_out_t         r_out;
    logic             r_done_seen;
    logic             r_cmd_err;
    logic             r_scan_empty;

    logic             w_accept;
    logic             w_auto_halt;
    logic             w_arg_zero;
    logic             w_flag_err;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_value;
    logic             w_cnt_en;
    logic             w_cnt_zero;

    assign w_accept    = cmd_if.cmd_valid && r_out.cmd_ready;
    assign w_auto_halt = AUTO_HALT_ON_DONE && (r_state == StRun) && i_core_done;
    assign w_arg_zero  = (cmd_if.cmd_arg == '0);
    assign w_flag_err  = (cmd_if.cmd_op >= 3'd6) ||
                         ((r_state == StRun) &&
                          ((cmd_if.cmd_op == OP_STEP) || (cmd_if.cmd_op == OP_SCAN)));
    assign w_cnt_en    = (r_state == StRstHold) || (r_state == StStep) || (r_state == StShift);

    // Counter is loaded on the accepting edge so cmd_arg need not stay stable afterwards.
    always_comb begin
        w_cnt_load  = 1'b0;
        w_cnt_value = cmd_if.cmd_arg - CNT_W'(1);
        if (w_accept && !w_auto_halt) begin
            if (cmd_if.cmd_op == OP_CORE_RESET) begin
                w_cnt_load  = 1'b1;
                w_cnt_value = RstCnt;
            end else if (((cmd_if.cmd_op == OP_STEP) || (cmd_if.cmd_op == OP_SCAN)) &&
                         (r_state == StHalted) && !w_arg_zero) begin
                w_cnt_load = 1'b1;
            end
        end
    end

    dbg_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (RstCnt)
    ) u_cnt (
        .i_clk   (i_sysclk),
        .i_rst   (i_sys_reset),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_en    (w_cnt_en),
        .o_zero  (w_cnt_zero)
    );

    always_ff @(posedge i_sysclk) begin
        if (i_sys_reset) begin
            r_state      <= StRstHold;
            r_out        <= state_outputs(StRstHold);
            r_done_seen  <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_scan_empty <= 1'b0;
        end else begin
            case (r_state)
                StRstHold: begin
                    if (w_cnt_zero) begin
                        r_state <= StRun;
                        r_out   <= state_outputs(StRun);
                    end
                end
                StRun, StHalted: begin
                    if (w_auto_halt) begin
                        r_state <= StHalted;
                        r_out   <= state_outputs(StHalted);
                    end else if (w_accept) begin
                        case (cmd_if.cmd_op)
                            OP_HALT: begin
                                r_state <= StHalted;
                                r_out   <= state_outputs(StHalted);
                            end
                            OP_RESUME: begin
                                r_state <= StRun;
                                r_out   <= state_outputs(StRun);
                            end
                            OP_STEP: begin
                                if ((r_state == StHalted) && !w_arg_zero) begin
                                    r_state <= StStep;
                                    r_out   <= state_outputs(StStep);
                                end
                            end
                            OP_SCAN: begin
                                if (r_state == StHalted) begin
                                    r_state      <= StCapture;
                                    r_out        <= state_outputs(StCapture);
                                    r_scan_empty <= w_arg_zero;
                                end
                            end
                            OP_CORE_RESET: begin
                                r_state     <= StRstHold;
                                r_out       <= state_outputs(StRstHold);
                                r_done_seen <= 1'b0;
                                r_cmd_err   <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    // Illegal commands are flagged even when auto-halt discards them.
                    if (w_accept && w_flag_err) begin
                        r_cmd_err <= 1'b1;
                    end
                end
                StStep: begin
                    if (w_cnt_zero || i_core_done) begin
                        r_state <= StHalted;
                        r_out   <= state_outputs(StHalted);
                    end
                end
                StCapture: begin
                    if (r_scan_empty) begin
                        r_state <= StUpdate;
                        r_out   <= state_outputs(StUpdate);
                    end else begin
                        r_state <= StShift;
                        r_out   <= state_outputs(StShift);
                    end
                end
                StShift: begin
                    if (w_cnt_zero) begin
                        r_state <= StUpdate;
                        r_out   <= state_outputs(StUpdate);
                    end
                end
                StUpdate: begin
                    r_state <= StHalted;
                    r_out   <= state_outputs(StHalted);
                end
                default: begin
                    r_state <= StRstHold;
                    r_out   <= state_outputs(StRstHold);
                end
            endcase
            if (i_core_done) begin
                r_done_seen <= 1'b1;
            end
        end
    end

    assign cmd_if.cmd_ready = r_out.cmd_ready;
    assign o_core_en        = r_out.core_en;
    assign o_core_reset     = r_out.core_reset;
    assign o_scan_capture   = r_out.scan_capture;
    assign o_scan_en        = r_out.scan_en;
    assign o_scan_update    = r_out.scan_update;
    assign o_halted         = r_out.halted;
    assign o_done_seen      = r_done_seen;
    assign o_cmd_err        = r_cmd_err;

endmodule

// File: tb/tb_jtag_debug_ctrl.sv
// Directed plus randomized bench for jtag_debug_ctrl against a queue/count-based model.
module tb_jtag_debug_ctrl;

    localparam int CW = 16;
    localparam int RC = 4;

    logic clk = 1'b0;
    logic rst;
    logic done;
    logic core_en, core_reset, scan_capture, scan_en, scan_update;
    logic halted, done_seen, cmd_err;

    jtag_debug_ctrl_if #(.CNT_W(CW)) cif ();

    jtag_debug_ctrl #(
        .CNT_W             (CW),
        .RESET_CYCLES      (RC),
        .AUTO_HALT_ON_DONE (1'b1)
    ) dut (
        .i_sysclk       (clk),
        .i_sys_reset    (rst),
        .cmd_if         (cif.slave),
        .i_core_done    (done),
        .o_core_en      (core_en),
        .o_core_reset   (core_reset),
        .o_scan_capture (scan_capture),
        .o_scan_en      (scan_en),
        .o_scan_update  (scan_update),
        .o_halted       (halted),
        .o_done_seen    (done_seen),
        .o_cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    // Model: remaining reset-hold cycles, remaining step cycles, a queue of
    // scheduled scan phases (1 capture, 2 shift, 3 update), and a run/halt flag.
    int m_rst_left;
    int m_step_left;
    int m_scan_q[$];
    bit m_run;
    bit m_done;
    bit m_err;

    int total = 0;
    int bad   = 0;

    function automatic bit m_busy();
        return (m_rst_left > 0) || (m_step_left > 0) || (m_scan_q.size() > 0);
    endfunction

    function automatic bit m_ready();
        return !m_busy();
    endfunction

    function automatic void model_edge();
        bit acc;
        bit hbd;
        int arg;
        acc = cif.cmd_valid && m_ready();
        arg = int'(cif.cmd_arg);
        if (rst) begin
            m_rst_left  = RC;
            m_step_left = 0;
            m_scan_q.delete();
            m_run  = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
            return;
        end
        if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (m_step_left > 0) begin
            m_step_left = done ? 0 : m_step_left - 1;
        end else if (m_scan_q.size() > 0) begin
            void'(m_scan_q.pop_front());
        end else begin
            hbd = m_run && done;
            if (acc) begin
                case (int'(cif.cmd_op))
                    1: m_run = 1'b0;
                    2: if (!hbd) m_run = 1'b1;
                    3: begin
                        if (m_run) m_err = 1'b1;
                        else m_step_left = arg;
                    end
                    4: begin
                        if (m_run) m_err = 1'b1;
                        else begin
                            m_scan_q.push_back(1);
                            for (int i = 0; i < arg; i++) m_scan_q.push_back(2);
                            m_scan_q.push_back(3);
                        end
                    end
                    5: begin
                        if (!hbd) begin
                            m_rst_left = RC;
                            m_run  = 1'b1;
                            m_done = 1'b0;
                            m_err  = 1'b0;
                        end
                    end
                    6, 7: m_err = 1'b1;
                    default: ;
                endcase
            end
            if (hbd) m_run = 1'b0;
        end
        if (done) m_done = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int ph;
        ph = (m_scan_q.size() > 0) ? m_scan_q[0] : 0;
        chk("core_reset", core_reset, m_rst_left > 0);
        chk("core_en", core_en, (m_rst_left == 0) &&
            ((m_step_left > 0) || (!m_busy() && m_run)));
        chk("cmd_ready", cif.cmd_ready, m_ready());
        chk("halted", halted, !m_busy() && !m_run);
        chk("scan_capture", scan_capture, ph == 1);
        chk("scan_en", scan_en, ph == 2);
        chk("scan_update", scan_update, ph == 3);
        chk("done_seen", done_seen, m_done);
        chk("cmd_err", cmd_err, m_err);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [2:0] op, input logic [CW-1:0] arg);
        int n;
        n = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_arg   = arg;
        while (!m_ready() && n < 500) begin
            tick();
            n++;
        end
        total++;
        assert (n < 500) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d expected=<500", n);
        end
        tick();
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_arg   = '0;
    endtask

    initial begin
        int c, c_cap, c_en, c_up;
        bit acc, was_rst;
        rst = 1'b1;
        done = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = '0;
        cif.cmd_arg   = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset release: core_reset for exactly RC cycles, then running
        c = int'(core_reset);
        repeat (8) begin
            tick();
            c += int'(core_reset);
        end
        chk_int("reset_hold_cycles", c, 4);
        chk("run_core_en", core_en, 1'b1);

        // HALT then STEP 5
        send(3'd1, '0);
        chk("halt_after_halt", halted, 1'b1);
        send(3'd3, 16'd5);
        c = int'(core_en);
        repeat (9) begin
            tick();
            c += int'(core_en);
        end
        chk_int("step5_cycles", c, 5);
        chk("step5_halted", halted, 1'b1);

        // SCAN 8
        send(3'd4, 16'd8);
        c_cap = int'(scan_capture);
        c_en  = int'(scan_en);
        c_up  = int'(scan_update);
        repeat (13) begin
            tick();
            c_cap += int'(scan_capture);
            c_en  += int'(scan_en);
            c_up  += int'(scan_update);
        end
        chk_int("scan8_capture", c_cap, 1);
        chk_int("scan8_shift", c_en, 8);
        chk_int("scan8_update", c_up, 1);
        chk("scan8_halted", halted, 1'b1);

        // SCAN 0: capture immediately followed by update
        send(3'd4, '0);
        chk("scan0_capture", scan_capture, 1'b1);
        tick();
        chk("scan0_update", scan_update, 1'b1);
        tick();
        chk("scan0_halted", halted, 1'b1);

        // STEP while running
        send(3'd2, '0);
        tick();
        send(3'd3, 16'd4);
        chk("step_in_run_err", cmd_err, 1'b1);
        chk("step_in_run_en", core_en, 1'b1);

        // CORE_RESET clears the error, then a reserved opcode sets it again
        send(3'd5, '0);
        repeat (6) tick();
        chk("core_reset_clears_err", cmd_err, 1'b0);
        send(3'd7, '0);
        chk("op7_err", cmd_err, 1'b1);

        send(3'd5, '0);
        c = int'(core_reset);
        repeat (7) begin
            tick();
            c += int'(core_reset);
        end
        chk_int("core_reset_cycles", c, 4);
        chk("core_reset_err_clear", cmd_err, 1'b0);

        // core_done together with RESUME in RUN: auto-halt wins
        done = 1'b1;
        send(3'd2, '0);
        done = 1'b0;
        chk("done_resume_halted", halted, 1'b1);
        chk("done_resume_seen", done_seen, 1'b1);

        // STEP 100 truncated by core_done on its 10th cycle
        send(3'd3, 16'd100);
        c = int'(core_en);
        repeat (9) begin
            tick();
            c += int'(core_en);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_int("step100_cycles", c, 10);
        chk("step100_halted", halted, 1'b1);
        chk("step100_en_off", core_en, 1'b0);

        // sys_reset on the 7th shift cycle of SCAN 20
        send(3'd4, 16'd20);
        repeat (7) tick();
        chk("shift7_active", scan_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_scan_en", scan_en, 1'b0);
        chk("abort_core_reset", core_reset, 1'b1);
        repeat (8) tick();

        // Randomized traffic; the source holds each command until accepted
        for (int k = 0; k < 3000; k++) begin
            if (!cif.cmd_valid && $urandom_range(0, 2) == 0) begin
                cif.cmd_valid = 1'b1;
                cif.cmd_op    = 3'($urandom_range(0, 7));
                if (cif.cmd_op == 3'd3 && $urandom_range(0, 15) == 0) cif.cmd_arg = 16'hFFFF;
                else cif.cmd_arg = 16'($urandom_range(0, 12));
            end
            done = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 599) == 0);
            acc     = cif.cmd_valid && m_ready();
            was_rst = rst;
            tick();
            if (acc || was_rst) cif.cmd_valid = 1'b0;
        end
        done = 1'b0;
        rst  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
